// File: rtl/fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// fetch_unit_pkg: shared widths, reset address and prefetch entry layout
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fetch_unit_pkg;

  localparam int unsigned DEF_PC_W     = 12;
  localparam int unsigned INSTR_W      = 32;
  localparam logic [11:0] DEF_RESET_PC = 12'h000;

  typedef struct packed {
    logic [DEF_PC_W-1:0] pc;
    logic [INSTR_W-1:0]  instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_sync_fifo.sv
// ----------------------------------------------------------------------------
// fetch_unit_sync_fifo: show-ahead FIFO with single-cycle flush
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_unit_sync_fifo #(
  parameter int unsigned WIDTH = 44,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit: PC sequencing, credit-limited imem requests, prefetch queue
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     PC_W     = DEF_PC_W,
  parameter int unsigned     DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               dec_ready,
  output logic               dec_valid,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [PC_W-1:0]    dec_pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata
);

  localparam int unsigned      CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CREDITS = CNT_W'(DEPTH);
  localparam logic [PC_W-1:0]  PC_STEP = PC_W'(4);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]  resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [CNT_W-1:0] count;
  logic [PC_W-1:0]  redirect_pc_aligned;
  logic             grant;
  logic             keep_resp;
  logic             push;
  logic             pop;
  entry_t           wr_entry;
  entry_t           head_entry;

  assign redirect_pc_aligned = {redirect_pc[PC_W-1:2], 2'b00};

  // Queue slots plus in-flight requests never exceed DEPTH, so a push always fits.
  assign imem_req  = !rst && !redirect && ((count + outstanding_q) < CREDITS);
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req && imem_gnt;

  assign keep_resp = imem_rvalid && (discard_q == '0);
  assign push      = keep_resp && !redirect;
  assign dec_valid = (count != '0) && !redirect;
  assign pop       = dec_valid && dec_ready;

  assign wr_entry  = '{pc: resp_pc_q, instr: imem_rdata};
  assign dec_pc    = head_entry.pc;
  assign dec_instr = head_entry.instr;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(imem_rvalid);
    if (grant) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
    if (imem_rvalid && (discard_q != '0)) begin
      discard_d = discard_q - CNT_W'(1);
    end
    if (keep_resp) begin
      resp_pc_d = resp_pc_q + PC_STEP;
    end
    // Everything still in flight after this cycle belongs to the old stream.
    if (redirect) begin
      fetch_pc_d = redirect_pc_aligned;
      resp_pc_d  = redirect_pc_aligned;
      discard_d  = outstanding_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_unit_sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (head_entry),
    .count_o (count)
  );

  a_rvalid_has_request: assert property (
    @(posedge clk) disable iff (rst) imem_rvalid |-> (outstanding_q != '0)
  );

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit: scoreboard bench for fetch_unit with an in-order imem model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

  localparam int          PC_W   = 12;
  localparam int          DEPTH  = 2;
  localparam logic [11:0] RST_PC = 12'hFFC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [11:0] redirect_pc = '0;
  logic        dec_ready = 1'b0;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [11:0] dec_pc;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mem_lat  = 1;

  logic [11:0] exp_q[$];
  logic [11:0] exp_a[$];
  logic [11:0] pend_addr[$];
  int          pend_due[$];

  always #5 clk = ~clk;

  fetch_unit #(
    .PC_W     (PC_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dec_ready   (dec_ready),
    .dec_valid   (dec_valid),
    .dec_instr   (dec_instr),
    .dec_pc      (dec_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata)
  );

  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return {20'hC0DE5, a};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // In-order memory: decides gnt/rvalid for the coming posedge after inputs settle.
  always @(negedge clk) begin
    #2;
    imem_rvalid = 1'b0;
    if (rst) begin
      pend_addr.delete();
      pend_due.delete();
    end else begin
      if (pend_due.size() > 0 && pend_due[0] <= cyc + 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (imem_req && imem_gnt) begin
        pend_addr.push_back(imem_addr);
        pend_due.push_back(cyc + 1 + mem_lat);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached, required finish before 200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; dec_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dec_valid: got %b expected 0", dec_valid); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_imem_req: got %b expected 0", imem_req); end
    n_checks++; if (dec_pc !== 12'h000) begin n_fail++; $display("FAIL reset_dec_pc: got %h expected 000", dec_pc); end
    n_checks++; if (dec_instr !== 32'h0) begin n_fail++; $display("FAIL reset_dec_instr: got %h expected 0", dec_instr); end
    @(negedge clk); rst = 1'b0; dec_ready = 1'b1; #1;
  endtask

  task automatic test_pc_wrap();
    exp_a.delete(); exp_q.delete();
    exp_a.push_back(12'hFFC); exp_a.push_back(12'h000); exp_a.push_back(12'h004);
    exp_q.push_back(12'hFFC); exp_q.push_back(12'h000); exp_q.push_back(12'h004);
    for (int i = 0; i < 40 && (exp_q.size() > 0 || exp_a.size() > 0); i++) begin
      if (imem_req && exp_a.size() > 0) begin
        n_checks++;
        if (imem_addr !== exp_a[0]) begin n_fail++; $display("FAIL wrap_addr: got %h expected %h", imem_addr, exp_a[0]); end
        void'(exp_a.pop_front());
      end
      if (dec_valid && dec_ready && exp_q.size() > 0) begin
        n_checks++;
        if (dec_pc !== exp_q[0] || dec_instr !== mem_word(exp_q[0])) begin
          n_fail++; $display("FAIL wrap_dec: got %h/%h expected %h/%h", dec_pc, dec_instr, exp_q[0], mem_word(exp_q[0]));
        end
        void'(exp_q.pop_front());
      end
      @(negedge clk); #1;
    end
    n_checks++; if (exp_q.size() + exp_a.size() != 0) begin n_fail++; $display("FAIL wrap_drain: %0d left expected 0", exp_q.size() + exp_a.size()); end
  endtask

  task automatic test_stream();
    mem_lat = 1;
    @(negedge clk); redirect = 1'b1; redirect_pc = 12'h000; dec_ready = 1'b1; #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stream_req_in_redirect: got %b expected 0", imem_req); end
    @(negedge clk); redirect = 1'b0; #1;
    exp_a.delete(); exp_q.delete();
    for (int k = 0; k < 6; k++) begin
      exp_a.push_back(12'(4 * k));
      exp_q.push_back(12'(4 * k));
    end
    for (int i = 0; i < 60 && (exp_q.size() > 0 || exp_a.size() > 0); i++) begin
      if (imem_req && exp_a.size() > 0) begin
        n_checks++;
        if (imem_addr !== exp_a[0]) begin n_fail++; $display("FAIL stream_addr: got %h expected %h", imem_addr, exp_a[0]); end
        void'(exp_a.pop_front());
      end
      if (dec_valid && dec_ready && exp_q.size() > 0) begin
        n_checks++;
        if (dec_pc !== exp_q[0] || dec_instr !== mem_word(exp_q[0])) begin
          n_fail++; $display("FAIL stream_dec: got %h/%h expected %h/%h", dec_pc, dec_instr, exp_q[0], mem_word(exp_q[0]));
        end
        void'(exp_q.pop_front());
      end
      @(negedge clk); #1;
    end
    n_checks++; if (exp_q.size() + exp_a.size() != 0) begin n_fail++; $display("FAIL stream_drain: %0d left expected 0", exp_q.size() + exp_a.size()); end
  endtask

  task automatic test_stall();
    int grants = 0;
    mem_lat = 1;
    @(negedge clk); redirect = 1'b1; redirect_pc = 12'h000; dec_ready = 1'b0; #1;
    repeat (10) begin
      @(negedge clk); redirect = 1'b0; #1;
      if (imem_req) grants++;
    end
    n_checks++; if (grants != 2) begin n_fail++; $display("FAIL stall_grants: got %0d expected 2", grants); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req: got %b expected 0", imem_req); end
    n_checks++; if (dec_valid !== 1'b1 || dec_pc !== 12'h000) begin n_fail++; $display("FAIL stall_head: got %b/%h expected 1/000", dec_valid, dec_pc); end
    dec_ready = 1'b1;
    exp_a.delete(); exp_q.delete();
    exp_a.push_back(12'h008);
    exp_q.push_back(12'h000); exp_q.push_back(12'h004); exp_q.push_back(12'h008);
    for (int i = 0; i < 40 && (exp_q.size() > 0 || exp_a.size() > 0); i++) begin
      if (imem_req && exp_a.size() > 0) begin
        n_checks++;
        if (imem_addr !== exp_a[0]) begin n_fail++; $display("FAIL stall_resume_addr: got %h expected %h", imem_addr, exp_a[0]); end
        void'(exp_a.pop_front());
      end
      if (dec_valid && dec_ready && exp_q.size() > 0) begin
        n_checks++;
        if (dec_pc !== exp_q[0] || dec_instr !== mem_word(exp_q[0])) begin
          n_fail++; $display("FAIL stall_dec: got %h/%h expected %h/%h", dec_pc, dec_instr, exp_q[0], mem_word(exp_q[0]));
        end
        void'(exp_q.pop_front());
      end
      @(negedge clk); #1;
    end
    n_checks++; if (exp_q.size() + exp_a.size() != 0) begin n_fail++; $display("FAIL stall_drain: %0d left expected 0", exp_q.size() + exp_a.size()); end
  endtask

  task automatic test_redirect_inflight();
    int g = 0;
    mem_lat = 3;
    @(negedge clk); redirect = 1'b1; redirect_pc = 12'h040; dec_ready = 1'b1; #1;
    for (int i = 0; i < 20 && g < 2; i++) begin
      @(negedge clk); redirect = 1'b0; #1;
      if (imem_req) g++;
    end
    n_checks++; if (g != 2) begin n_fail++; $display("FAIL inflight_grants: got %0d expected 2", g); end
    @(negedge clk); redirect = 1'b1; redirect_pc = 12'h100; #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL inflight_req_in_redirect: got %b expected 0", imem_req); end
    @(negedge clk); redirect = 1'b0; #1;
    exp_q.delete();
    exp_q.push_back(12'h100); exp_q.push_back(12'h104); exp_q.push_back(12'h108);
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) begin
      if (dec_valid && dec_ready) begin
        n_checks++;
        if (dec_pc !== exp_q[0] || dec_instr !== mem_word(exp_q[0])) begin
          n_fail++; $display("FAIL inflight_dec: got %h/%h expected %h/%h", dec_pc, dec_instr, exp_q[0], mem_word(exp_q[0]));
        end
        void'(exp_q.pop_front());
      end
      @(negedge clk); #1;
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL inflight_drain: %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_redirect_grant();
    logic seen = 1'b0;
    mem_lat = 1;
    @(negedge clk); redirect = 1'b1; redirect_pc = 12'h008; dec_ready = 1'b1; #1;
    @(negedge clk); redirect = 1'b0; #1;
    exp_q.delete();
    exp_q.push_back(12'h008); exp_q.push_back(12'h00C);
    for (int i = 0; i < 20; i++) begin
      if (dec_valid && dec_ready && exp_q.size() > 0) begin
        n_checks++;
        if (dec_pc !== exp_q[0] || dec_instr !== mem_word(exp_q[0])) begin
          n_fail++; $display("FAIL grant_pre_dec: got %h/%h expected %h/%h", dec_pc, dec_instr, exp_q[0], mem_word(exp_q[0]));
        end
        void'(exp_q.pop_front());
      end
      if (imem_req && imem_addr == 12'h010) seen = 1'b1;
      if (seen) break;
      @(negedge clk); #1;
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL grant_seen_010: got %b expected 1", seen); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL grant_pre_drain: %0d left expected 0", exp_q.size()); end
    @(negedge clk); redirect = 1'b1; redirect_pc = 12'h080; #1;
    n_checks++; if (imem_req !== 1'b0 || dec_valid !== 1'b0) begin n_fail++; $display("FAIL grant_redirect_cycle: got req %b valid %b expected 0 0", imem_req, dec_valid); end
    @(negedge clk); redirect = 1'b0; #1;
    exp_q.delete();
    exp_q.push_back(12'h080); exp_q.push_back(12'h084); exp_q.push_back(12'h088);
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      if (dec_valid && dec_ready) begin
        n_checks++;
        if (dec_pc !== exp_q[0] || dec_instr !== mem_word(exp_q[0])) begin
          n_fail++; $display("FAIL grant_dec: got %h/%h expected %h/%h", dec_pc, dec_instr, exp_q[0], mem_word(exp_q[0]));
        end
        void'(exp_q.pop_front());
      end
      @(negedge clk); #1;
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL grant_drain: %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back_redirect();
    int g = 0;
    mem_lat = 3;
    @(negedge clk); redirect = 1'b1; redirect_pc = 12'h040; dec_ready = 1'b1; #1;
    for (int i = 0; i < 20 && g < 2; i++) begin
      @(negedge clk); redirect = 1'b0; #1;
      if (imem_req) g++;
    end
    @(negedge clk); redirect = 1'b1; redirect_pc = 12'h200; #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL b2b_req_first: got %b expected 0", imem_req); end
    // Misaligned target: low bits must be ignored.
    @(negedge clk); redirect = 1'b1; redirect_pc = 12'h303; #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL b2b_req_second: got %b expected 0", imem_req); end
    @(negedge clk); redirect = 1'b0; #1;
    exp_q.delete();
    exp_q.push_back(12'h300); exp_q.push_back(12'h304); exp_q.push_back(12'h308);
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) begin
      if (dec_valid && dec_ready) begin
        n_checks++;
        if (dec_pc !== exp_q[0] || dec_instr !== mem_word(exp_q[0])) begin
          n_fail++; $display("FAIL b2b_dec: got %h/%h expected %h/%h", dec_pc, dec_instr, exp_q[0], mem_word(exp_q[0]));
        end
        void'(exp_q.pop_front());
      end
      @(negedge clk); #1;
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_drain: %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_rst_midstream();
    mem_lat = 1;
    @(negedge clk); redirect = 1'b1; redirect_pc = 12'h020; dec_ready = 1'b1; #1;
    @(negedge clk); redirect = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1; #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req: got %b expected 0", imem_req); end
    @(negedge clk); rst = 1'b0; #1;
    n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_dec_valid: got %b expected 0", dec_valid); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin n_fail++; $display("FAIL rst_mid_restart: got %b/%h expected 1/%h", imem_req, imem_addr, RST_PC); end
    exp_q.delete();
    exp_q.push_back(12'hFFC); exp_q.push_back(12'h000);
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      if (dec_valid && dec_ready) begin
        n_checks++;
        if (dec_pc !== exp_q[0] || dec_instr !== mem_word(exp_q[0])) begin
          n_fail++; $display("FAIL rst_mid_dec: got %h/%h expected %h/%h", dec_pc, dec_instr, exp_q[0], mem_word(exp_q[0]));
        end
        void'(exp_q.pop_front());
      end
      @(negedge clk); #1;
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rst_mid_drain: %0d left expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_pc_wrap();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_grant();
    test_back_to_back_redirect();
    test_rst_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
